// File: rtl/fft_io_sequencer.sv
// Frame sequencer for fft_top: scatters a stream of real samples into the four
// RAM banks with the digit-sum mapping, fires the core, waits for completion,
// then reads the banks back and streams the results out with valid/ready.
module fft_io_sequencer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [DATA_W-1:0] iIN_DATA,
  input  logic              iIN_VALID,
  output logic              oIN_READY,
  output logic [DATA_W-1:0] oFFT_DATA,
  output logic [ADDR_W-1:0] oADDR_WR,
  output logic [3:0]        oWE,
  output logic [ADDR_W-1:0] oADDR_RD,
  output logic              oFFT_START,
  input  logic              iFFT_RDY,
  input  logic [DATA_W:0]   iRD_DATA_0,
  input  logic [DATA_W:0]   iRD_DATA_1,
  input  logic [DATA_W:0]   iRD_DATA_2,
  input  logic [DATA_W:0]   iRD_DATA_3,
  output logic [DATA_W:0]   oOUT_DATA,
  output logic [1:0]        oOUT_BANK,
  output logic [ADDR_W-1:0] oOUT_ADDR,
  output logic              oOUT_VALID,
  input  logic              iOUT_READY,
  output logic              oOUT_LAST,
  output logic              oBUSY
);

  localparam int IDX_W = ADDR_W + 2;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = {IDX_W{1'b1}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [LAT_W-1:0]  LAT_END   = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_RDADDR, S_CAPT, S_EMIT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  n;
  logic [ADDR_W-1:0] a;
  logic [1:0]        b;
  logic [LAT_W-1:0]  lat;
  logic              rdy_prev;
  logic [DATA_W:0]   hold [4];
  logic              in_ready;
  logic              accept;
  logic              out_fire;
  logic              rdy_edge;

  // Bank of a sample index: sum of its base-4 digits, modulo 4. The index is
  // zero-padded by one bit so an odd-width top digit reads as a 2-bit digit.
  function automatic logic [1:0] bank_of(input logic [IDX_W-1:0] idx);
    logic [IDX_W:0] p;
    logic [1:0]     s;
    p = {1'b0, idx};
    s = 2'd0;
    for (int i = 0; i < IDX_W; i += 2) begin
      s = s + p[i +: 2];
    end
    return s;
  endfunction

  // Handshake qualifiers shared by the state logic and the outputs.
  always_comb begin
    in_ready = 1'b0;
    if (!iRESET && (state == S_IDLE || state == S_LOAD)) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
    accept   = iIN_VALID && in_ready;
    out_fire = (state == S_EMIT) && iOUT_READY;
    // The level seen at START is preloaded as "high", so only a 0->1 seen
    // inside WAIT counts as completion.
    rdy_edge = (state == S_WAIT) && !rdy_prev && iFFT_RDY;
  end

  // Next-state decision.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_LOAD; else state_next = S_IDLE;
      S_LOAD:   if (accept && n == LAST_IDX) state_next = S_START; else state_next = S_LOAD;
      S_START:  state_next = S_WAIT;
      S_WAIT:   if (rdy_edge) state_next = S_RDADDR; else state_next = S_WAIT;
      S_RDADDR: if (lat == LAT_END) state_next = S_CAPT; else state_next = S_RDADDR;
      S_CAPT:   state_next = S_EMIT;
      S_EMIT: begin
        if (out_fire && b == 2'd3) begin
          if (a == LAST_ADDR) state_next = S_IDLE;
          else                state_next = S_RDADDR;
        end else begin
          state_next = S_EMIT;
        end
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // State register, sample/address/bank counters and the read holding buffer.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= S_IDLE;
      n        <= '0;
      a        <= '0;
      b        <= 2'd0;
      lat      <= '0;
      rdy_prev <= 1'b0;
      for (int k = 0; k < 4; k++) hold[k] <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          a <= '0;
          b <= 2'd0;
          if (accept) n <= IDX_W'(1);
          else        n <= '0;
        end
        S_LOAD: begin
          if (accept) n <= n + IDX_W'(1);
        end
        S_START: begin
          rdy_prev <= 1'b1;
        end
        S_WAIT: begin
          rdy_prev <= iFFT_RDY;
          if (rdy_edge) begin
            a   <= '0;
            lat <= '0;
          end
        end
        S_RDADDR: begin
          lat <= lat + LAT_W'(1);
        end
        S_CAPT: begin
          hold[0] <= iRD_DATA_0;
          hold[1] <= iRD_DATA_1;
          hold[2] <= iRD_DATA_2;
          hold[3] <= iRD_DATA_3;
          b       <= 2'd0;
          lat     <= '0;
        end
        S_EMIT: begin
          if (out_fire) begin
            b <= b + 2'd1;
            if (b == 2'd3) begin
              if (a == LAST_ADDR) a <= '0;
              else                a <= a + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: writes only exist in an accept cycle, results only in EMIT.
  always_comb begin
    oIN_READY  = in_ready;
    oWE        = 4'b0000;
    oADDR_WR   = '0;
    oFFT_DATA  = '0;
    if (accept) begin
      oWE       = 4'b0001 << bank_of(n);
      oADDR_WR  = n[IDX_W-1:2];
      oFFT_DATA = iIN_DATA;
    end else begin
      oWE       = 4'b0000;
    end
    oADDR_RD   = a;
    oFFT_START = (state == S_START) && !iRESET;
    oBUSY      = (state != S_IDLE);
    oOUT_VALID = (state == S_EMIT);
    oOUT_DATA  = '0;
    oOUT_BANK  = 2'd0;
    oOUT_ADDR  = '0;
    oOUT_LAST  = 1'b0;
    if (state == S_EMIT) begin
      oOUT_DATA = hold[b];
      oOUT_BANK = b;
      oOUT_ADDR = a;
      oOUT_LAST = (a == LAST_ADDR) && (b == 2'd3);
    end else begin
      oOUT_LAST = 1'b0;
    end
  end

endmodule

// File: doc/fft_io_sequencer.md
# fft_io_sequencer

Frame-level sequencer that sits in front of `fft_top` and owns its external load/unload ports.
- Accepts a stream of real 16-bit samples and scatters them into the four RAM banks using the conflict-free digit-sum mapping.
- Pulses the FFT start, waits for completion, then reads the four banks back and emits the 17-bit real results as a valid/ready stream.
- Guarantees the external RAM ports are never driven while the FFT core owns the memory.

## Interface
Parameters:
- `ADDR_W`, 9: per-bank address width; frame length N = 4·2^ADDR_W (2048).
- `DATA_W`, 16: input sample width; output width is DATA_W+1.
- `RD_LAT`, 2: cycles from `oADDR_RD` change to valid `iRD_DATA_x`.

Ports:
- `iCLK` in 1: single clock; all logic on the rising edge.
- `iRESET` in 1: synchronous, active-high reset.
- `iIN_DATA` in DATA_W: input sample.
- `iIN_VALID` in 1: sample valid.
- `oIN_READY` out 1: sequencer accepts the sample this cycle.
- `oFFT_DATA` out DATA_W: sample to fft_top `iDATA`.
- `oADDR_WR` out ADDR_W: write address, fanned to all four `iADDR_WR_x`.
- `oWE` out 4: one-hot bank write enable, to `iWE_0..3`.
- `oADDR_RD` out ADDR_W: read address, fanned to all four `iADDR_RD_x`.
- `oFFT_START` out 1: one-cycle start pulse, to `iSTART`.
- `iFFT_RDY` in 1: from fft_top `oRDY`.
- `iRD_DATA_0..3` in DATA_W+1 each: from `oDATA_RE_0..3`.
- `oOUT_DATA` out DATA_W+1: result word.
- `oOUT_BANK` out 2: bank tag of the current word.
- `oOUT_ADDR` out ADDR_W: address tag of the current word.
- `oOUT_VALID` out 1: result word valid.
- `iOUT_READY` in 1: downstream accepts the result word.
- `oOUT_LAST` out 1: marks the final word of a frame.
- `oBUSY` out 1: high in every state except IDLE.

## Operation
States: IDLE, LOAD, START, WAIT, RDADDR, CAPT, EMIT.

Sample mapping:
- Sample index n has ADDR_W+2 bits.
- Bank = (sum of the base-4 digits of n) mod 4. Digits are n[1:0], n[3:2], …; the top digit is 1 bit when ADDR_W+2 is odd.
- Address = n[ADDR_W+1:2].

State behaviour:
- IDLE: `oIN_READY`=1. Counter n=0. An accepted sample (valid and ready) goes to LOAD and is written as n=0.
- LOAD: `oIN_READY`=1. Each accepted sample drives `oFFT_DATA`=sample, `oADDR_WR`=address(n), and `oWE`=one-hot(bank(n)) in the same cycle (combinational from the registered-stage inputs), then n++. When sample N−1 is accepted, go to START. Non-valid cycles leave `oWE`=0.
- START: `oFFT_START`=1 for exactly one cycle, `oIN_READY`=0, then go to WAIT.
- WAIT: wait for a rising edge of `iFFT_RDY` (sampled 0 then 1 on consecutive cycles, first sample taken the cycle after START). A level already high at START is not completion. On the edge, set address counter a=0 and go to RDADDR.
- RDADDR: drive `oADDR_RD`=a. Hold it for RD_LAT cycles, then go to CAPT.
- CAPT: register all four `iRD_DATA_x` into a 4-word holding buffer, set bank index b=0, go to EMIT.
- EMIT: `oOUT_VALID`=1 with `oOUT_DATA`=buffer[b], `oOUT_BANK`=b, `oOUT_ADDR`=a. On handshake, b++. After b=3 is accepted:
  - if a = 2^ADDR_W−1, go to IDLE;
  - otherwise a++ and go to RDADDR.
- `oOUT_LAST`=1 only on the word with a = 2^ADDR_W−1 and b=3.
- Output order is bank-major per address; index unscrambling is done downstream.
- `oWE` is 0 outside LOAD, so external writes never collide with the core's SOURCE_CONT window.
- While `oOUT_VALID`=1 and `iOUT_READY`=0, the data and tags hold stable.

## Timing
Reset values (synchronous, next edge):
- State IDLE; n=0, a=0, b=0.
- `oWE`=0, `oFFT_START`=0, `oOUT_VALID`=0, `oOUT_LAST`=0, `oBUSY`=0, `oIN_READY`=0 during the reset cycle, then 1.
- `oADDR_WR`=0, `oADDR_RD`=0, `oFFT_DATA`=0, `oOUT_DATA`=0, `oOUT_BANK`=0, `oOUT_ADDR`=0.
- Reset mid-frame aborts immediately with no further writes or starts; a partially loaded frame is discarded.

Latencies:
- Load: 1 sample per cycle, write issued in the accept cycle.
- START follows the cycle after the last accept.
- Unload per address: RD_LAT cycles in RDADDR + 1 in CAPT + at least 4 in EMIT. Full unload is at least 2^ADDR_W·(RD_LAT+5) cycles (3584 at the defaults).

Boundary behaviour:
- `iIN_VALID` in START, WAIT, or the read states is ignored and not accepted.
- A new frame may begin the cycle after returning to IDLE.
- A glitch or high level of `iFFT_RDY` during LOAD has no effect.

## Test plan
- Reset with `iIN_VALID`=1 → every output at its reset value, `oWE`=0. On release, the first sample is accepted and goes to n=0 (bank 0, addr 0).
- Stream n=0..2047 with data=n → n=4: bank 1 addr 1; n=5: bank 2 addr 1; n=2047: bank 0 addr 511. Exactly one `oWE` bit per accept, and 2048 writes in total.
- Gap insertion: `iIN_VALID` low every third cycle → `oWE`=0 on gap cycles, n does not advance, START occurs exactly once.
- Hold `iFFT_RDY`=1 through START, then drop it for 5 cycles and raise it → no read until the rising edge; the first `oADDR_RD`=0 appears the cycle after the edge.
- Model banks returning {addr, bank} patterns and hold `iOUT_READY`=0 for 3 cycles mid-EMIT → data and tags stable. The sequence is (0,0),(0,1),(0,2),(0,3),(1,0)…, `oOUT_LAST` only on (511,3), then the state returns to IDLE.
- Assert `iRESET` during WAIT and again during EMIT at b=2 → `oOUT_VALID` drops on the next edge, no `oFFT_START`, and the next frame loads cleanly from n=0.
